// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, write-enable levels and starvation FSM encodings for the
// register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REGBUS     = 32;
  localparam int REGADDRBUS = 5;
  localparam int REGNUM     = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

  function automatic logic [REGNUM-1:0] reg_onehot(input logic [REGADDRBUS-1:0] a);
    return REGNUM'(1) << a;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline / multi-cycle units and the write-port
// arbiter; slave is the arbiter side.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  pipe_we;
  logic [REGADDRBUS-1:0] pipe_waddr;
  logic [REGBUS-1:0]     pipe_wdata;
  logic                  mc_valid;
  logic                  mc_ready;
  logic [REGADDRBUS-1:0] mc_waddr;
  logic [REGBUS-1:0]     mc_wdata;
  logic                  rf_we;
  logic [REGADDRBUS-1:0] rf_waddr;
  logic [REGBUS-1:0]     rf_wdata;
  logic                  stall_req;
  logic [REGNUM-1:0]     pend_mask;
  logic                  waw_err;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, mc_valid, mc_waddr, mc_wdata,
    output mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_mask, waw_err
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, mc_valid, mc_waddr, mc_wdata,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_mask, waw_err
  );

endinterface

// File: rtl/wb_result_fifo.sv
// In-order result buffer; exposes per-entry valid/addr so the parent can build
// the pending-register mask.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [REGADDRBUS-1:0]            push_addr,
  input  logic [REGBUS-1:0]                push_data,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic                             last,
  output logic [REGADDRBUS-1:0]            head_addr,
  output logic [REGBUS-1:0]                head_data,
  output logic [DEPTH-1:0]                 ent_vld,
  output logic [DEPTH-1:0][REGADDRBUS-1:0] ent_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                      wr_ptr, rd_ptr;
  logic [AW-1:0]                    wr_idx, rd_idx;
  logic [DEPTH-1:0][REGADDRBUS-1:0] mem_addr;
  logic [REGBUS-1:0]                mem_data [DEPTH];
  logic [DEPTH-1:0]                 vld;
  logic                             push_ok, pop_ok;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign last    = ((wr_ptr - rd_ptr) == (AW+1)'(1));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      // indices differ whenever both fire, so the two vld updates never collide
      if (push_ok) begin
        vld[wr_idx] <= 1'b1;
        wr_ptr      <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        vld[rd_idx] <= 1'b0;
        rd_ptr      <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_addr[wr_idx] <= push_addr;
      mem_data[wr_idx] <= push_data;
    end
  end

  assign head_addr = mem_addr[rd_idx];
  assign head_data = mem_data[rd_idx];
  assign ent_vld   = vld;
  assign ent_addr  = mem_addr;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, buffered multi-cycle
// results drain into idle cycles, starvation forces a front-end stall.
//
// state | meaning
// IDLE  | buffer empty, blocked counter 0
// DRAIN | buffer non-empty, counting cycles the head is blocked
// FORCE | head blocked STARVE_MAX times, stall_req held until it pops
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic                             full, empty, last;
  logic                             push, pop;
  logic [REGADDRBUS-1:0]            head_addr;
  logic [REGBUS-1:0]                head_data;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REGADDRBUS-1:0] ent_addr;
  logic                             rf_we;
  logic [REGADDRBUS-1:0]            rf_waddr;
  logic [REGBUS-1:0]                rf_wdata;
  logic [REGNUM-1:0]                pend_mask;
  logic                             waw_err;
  wb_state_e                        state, state_nxt;
  logic [CW-1:0]                    cnt, cnt_nxt;

  // r0 results are acknowledged but never buffered
  assign push = bus.mc_valid && !full && (bus.mc_waddr != '0);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.mc_waddr),
    .push_data (bus.mc_wdata),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .last      (last),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    rf_we    = WRITE_DISABLE;
    rf_waddr = '0;
    rf_wdata = '0;
    pop      = 1'b0;
    if (bus.pipe_we) begin
      rf_we    = WRITE_ENABLE;
      rf_waddr = bus.pipe_waddr;
      rf_wdata = bus.pipe_wdata;
    end else if (!empty) begin
      rf_we    = WRITE_ENABLE;
      rf_waddr = head_addr;
      rf_wdata = head_data;
      pop      = 1'b1;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_addr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      waw_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (bus.pipe_we && (bus.pipe_waddr != '0) && pend_mask[bus.pipe_waddr])
        waw_err <= 1'b1;
    end
  end

  // FORCE is entered on the same edge the counter reaches STARVE_MAX
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (push) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop) begin
          cnt_nxt = '0;
          if (last && !push) state_nxt = ST_IDLE;
        end else if (bus.pipe_we && !empty) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == CW'(STARVE_MAX)) state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        if (pop) begin
          cnt_nxt   = '0;
          state_nxt = (last && !push) ? ST_IDLE : ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.mc_ready  = !full;
  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.stall_req = (state == ST_FORCE);
  assign bus.pend_mask = pend_mask;
  assign bus.waw_err   = waw_err;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model: buffered results, blocked-cycle count since last drain, sticky WAW
  ent_t        q[$];
  int          blk    = 0;
  logic        m_waw  = 1'b0;
  logic        mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] pm = '0;
    foreach (q[i]) pm = pm | (32'(1) << q[i].a);
    return pm;
  endfunction

  always @(posedge clk) begin
    logic [31:0] pm;
    logic        do_pop, do_push;
    if (rst) begin
      q.delete();
      blk    = 0;
      m_waw  = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      pm = model_pend();
      if (bus.pipe_we && bus.pipe_waddr != 0 && pm[bus.pipe_waddr]) m_waw = 1'b1;
      do_pop  = !bus.pipe_we && q.size() > 0;
      do_push = bus.mc_valid && q.size() < DEPTH && bus.mc_waddr != 0;
      if (do_pop) begin
        q.delete(0);
        blk = 0;
      end else if (bus.pipe_we && q.size() > 0 && blk < STARVE_MAX) begin
        blk++;
      end
      if (do_push) q.push_back('{bus.mc_waddr, bus.mc_wdata});
    end
  end

  always @(negedge clk) begin
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    if (mvalid) begin
      if (bus.pipe_we) begin
        e_we = 1'b1; e_a = bus.pipe_waddr; e_d = bus.pipe_wdata;
      end else if (q.size() > 0) begin
        e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
      end else begin
        e_we = 1'b0; e_a = '0; e_d = '0;
      end
      chk("m_rf_we",     32'(bus.rf_we),     32'(e_we));
      chk("m_rf_waddr",  32'(bus.rf_waddr),  32'(e_a));
      chk("m_rf_wdata",  bus.rf_wdata,       e_d);
      chk("m_mc_ready",  32'(bus.mc_ready),  32'(q.size() < DEPTH));
      chk("m_stall_req", 32'(bus.stall_req), 32'(blk >= STARVE_MAX));
      chk("m_pend_mask", bus.pend_mask,      model_pend());
      chk("m_waw_err",   32'(bus.waw_err),   32'(m_waw));
    end
  end

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.pipe_we    = pwe;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.mc_valid   = mv;
    bus.mc_waddr   = ma;
    bus.mc_wdata   = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1;
    drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    tick();
    drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_mc_ready", 32'(bus.mc_ready), 1);
    chk("rst_stall", 32'(bus.stall_req), 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_waw", 32'(bus.waw_err), 0);
    tick();

    // idle drain
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    settle();
    chk("idle_ready", 32'(bus.mc_ready), 1);
    chk("idle_no_we_yet", 32'(bus.rf_we), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("idle_we", 32'(bus.rf_we), 1);
    chk("idle_waddr", 32'(bus.rf_waddr), 5);
    chk("idle_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("idle_pend", bus.pend_mask, 32'h20);
    tick();
    settle();
    chk("idle_we_after", 32'(bus.rf_we), 0);
    chk("idle_pend_after", bus.pend_mask, 0);
    tick();

    // priority and starvation
    drive(1, 5'd7, 32'h22, 1, 5'd3, 32'h11);
    tick();
    drive(1, 5'd7, 32'h22, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("starve_waddr", 32'(bus.rf_waddr), 7);
      chk("starve_wdata", bus.rf_wdata, 32'h22);
      chk("starve_no_stall", 32'(bus.stall_req), 0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("starve_stall", 32'(bus.stall_req), 1);
      chk("starve_pipe_wins", 32'(bus.rf_waddr), 7);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("starve_drain_we", 32'(bus.rf_we), 1);
    chk("starve_drain_addr", 32'(bus.rf_waddr), 3);
    chk("starve_drain_data", bus.rf_wdata, 32'h11);
    chk("starve_stall_hold", 32'(bus.stall_req), 1);
    tick();
    settle();
    chk("starve_stall_fall", 32'(bus.stall_req), 0);
    chk("starve_we_fall", 32'(bus.rf_we), 0);
    tick();

    // full
    drive(1, 5'd7, 32'h1, 1, 5'd10, 32'hA);
    tick();
    drive(1, 5'd7, 32'h2, 1, 5'd11, 32'hB);
    settle();
    chk("full_ready1", 32'(bus.mc_ready), 1);
    tick();
    drive(1, 5'd7, 32'h3, 1, 5'd12, 32'hC);
    settle();
    chk("full_ready0", 32'(bus.mc_ready), 0);
    chk("full_pend", bus.pend_mask, 32'h0000_0C00);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("full_first_addr", 32'(bus.rf_waddr), 10);
    chk("full_first_data", bus.rf_wdata, 32'hA);
    tick();
    settle();
    chk("full_second_addr", 32'(bus.rf_waddr), 11);
    chk("full_second_data", bus.rf_wdata, 32'hB);
    tick();
    settle();
    chk("full_no_third", 32'(bus.rf_we), 0);
    tick();

    // r0 discard
    drive(0, 0, 0, 1, 5'd0, 32'h55);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("r0_no_we", 32'(bus.rf_we), 0);
    chk("r0_no_pend", bus.pend_mask, 0);
    tick();

    // WAW against a buffered r9
    drive(1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
    tick();
    drive(1, 5'd9, 32'h123, 0, 0, 0);
    settle();
    chk("waw_pend9", bus.pend_mask, 32'h200);
    chk("waw_not_yet", 32'(bus.waw_err), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("waw_set", 32'(bus.waw_err), 1);
    chk("waw_drain_addr", 32'(bus.rf_waddr), 9);
    tick();
    tick();
    settle();
    chk("waw_sticky", 32'(bus.waw_err), 1);
    tick();

    // reset mid-operation with two entries buffered and stall active
    drive(1, 5'd2, 32'h7, 1, 5'd20, 32'h20);
    tick();
    drive(1, 5'd2, 32'h7, 1, 5'd21, 32'h21);
    tick();
    drive(1, 5'd2, 32'h7, 0, 0, 0);
    repeat (3) tick();
    settle();
    chk("mid_stall", 32'(bus.stall_req), 1);
    chk("mid_pend", bus.pend_mask, 32'h0030_0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("mid_no_write", 32'(bus.rf_we), 0);
      chk("mid_pend_clr", bus.pend_mask, 0);
      chk("mid_stall_clr", 32'(bus.stall_req), 0);
      chk("mid_waw_clr", 32'(bus.waw_err), 0);
      tick();
    end

    // mixed traffic, model-checked
    for (int c = 0; c < 60; c++) begin
      drive(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
